mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-client / one-memory bus bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req, c_we, c_ack, c_err;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              l_req, l_we, l_ack, l_err;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata, l_rdata;
  logic              m_valid, m_we, m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    input  m_rdata, m_ready,
    output c_rdata, c_ack, c_err,
    output l_rdata, l_ack, l_err,
    output m_valid, m_we, m_addr, m_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_req, l_we, l_addr, l_wdata,
    output m_rdata, m_ready,
    input  c_rdata, c_ack, c_err,
    input  l_rdata, l_ack, l_err,
    input  m_valid, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin core/loader arbiter onto one memory port with access timeout
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q;
  logic              grant_core_q;
  logic              last_core_q;
  logic [7:0]        wait_q;
  logic              busy_q;
  logic              m_valid_q, m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] c_rdata_q, l_rdata_q;
  logic              c_ack_q, l_ack_q, c_err_q, l_err_q;
  logic              grant_core_d;

  // Core wins unless the loader also asks and the core had the previous grant.
  always_comb begin
    grant_core_d = bus.c_req && (!bus.l_req || !last_core_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_core_q <= 1'b0;
      last_core_q  <= 1'b0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      c_rdata_q    <= '0;
      l_rdata_q    <= '0;
      c_ack_q      <= 1'b0;
      l_ack_q      <= 1'b0;
      c_err_q      <= 1'b0;
      l_err_q      <= 1'b0;
    end else begin
      c_ack_q <= 1'b0;
      l_ack_q <= 1'b0;
      c_err_q <= 1'b0;
      l_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.c_req || bus.l_req) begin
            grant_core_q <= grant_core_d;
            last_core_q  <= grant_core_d;
            m_we_q       <= grant_core_d ? bus.c_we    : bus.l_we;
            m_addr_q     <= grant_core_d ? bus.c_addr  : bus.l_addr;
            m_wdata_q    <= grant_core_d ? bus.c_wdata : bus.l_wdata;
            m_valid_q    <= 1'b1;
            wait_q       <= '0;
            busy_q       <= 1'b1;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          // m_ready takes priority over an expiring wait counter.
          if (bus.m_ready) begin
            if (!m_we_q) begin
              if (grant_core_q) c_rdata_q <= bus.m_rdata;
              else              l_rdata_q <= bus.m_rdata;
            end
            c_ack_q   <= grant_core_q;
            l_ack_q   <= !grant_core_q;
            m_valid_q <= 1'b0;
            state_q   <= RESP;
          end else if (wait_q == TIMEOUT_C) begin
            c_ack_q   <= grant_core_q;
            l_ack_q   <= !grant_core_q;
            c_err_q   <= grant_core_q;
            l_err_q   <= !grant_core_q;
            m_valid_q <= 1'b0;
            state_q   <= RESP;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          m_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.c_rdata = c_rdata_q;
  assign bus.l_rdata = l_rdata_q;
  assign bus.c_ack   = c_ack_q;
  assign bus.l_ack   = l_ack_q;
  assign bus.c_err   = c_err_q;
  assign bus.l_err   = l_err_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (default and TIMEOUT=3 instances)
module tb_mem_arbiter;
  logic clk;
  logic reset_n;
  logic busy_d, busy_t;
  int   checks;
  int   errors;

  mem_arbiter_if bus_d ();
  mem_arbiter_if bus_t ();

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_d), .busy(busy_d)
  );

  mem_arbiter #(.TIMEOUT(3)) dut_t (
    .clk(clk), .reset_n(reset_n), .bus(bus_t), .busy(busy_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_d.c_req = 0; bus_d.c_we = 0; bus_d.c_addr = '0; bus_d.c_wdata = '0;
    bus_d.l_req = 0; bus_d.l_we = 0; bus_d.l_addr = '0; bus_d.l_wdata = '0;
    bus_d.m_ready = 0; bus_d.m_rdata = '0;
    bus_t.c_req = 0; bus_t.c_we = 0; bus_t.c_addr = '0; bus_t.c_wdata = '0;
    bus_t.l_req = 0; bus_t.l_we = 0; bus_t.l_addr = '0; bus_t.l_wdata = '0;
    bus_t.m_ready = 0; bus_t.m_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus_d.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", bus_d.m_valid); end
    checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_d); end
    checks++; if (bus_d.m_addr !== 32'h0) begin errors++; $display("FAIL rst_m_addr: got %h expected 0", bus_d.m_addr); end
    checks++; if (bus_d.m_wdata !== 32'h0) begin errors++; $display("FAIL rst_m_wdata: got %h expected 0", bus_d.m_wdata); end
    checks++; if (bus_d.m_we !== 1'b0) begin errors++; $display("FAIL rst_m_we: got %b expected 0", bus_d.m_we); end
    checks++; if (bus_d.c_rdata !== 32'h0 || bus_d.l_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h expected 0/0", bus_d.c_rdata, bus_d.l_rdata); end
    checks++; if ({bus_d.c_ack, bus_d.l_ack, bus_d.c_err, bus_d.l_err} !== 4'b0) begin errors++; $display("FAIL rst_ack_err: got %b expected 0000", {bus_d.c_ack, bus_d.l_ack, bus_d.c_err, bus_d.l_err}); end
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus_d.m_valid !== 1'b0 || busy_d !== 1'b0) begin errors++; $display("FAIL idle_no_req: got valid=%b busy=%b expected 0/0", bus_d.m_valid, busy_d); end
    end
  endtask

  task automatic test_round_robin();
    bus_d.c_req = 1; bus_d.c_we = 0; bus_d.c_addr = 32'h10;
    bus_d.l_req = 1; bus_d.l_we = 0; bus_d.l_addr = 32'h20;
    bus_d.m_ready = 1; bus_d.m_rdata = 32'h1111_2222;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (bus_d.c_ack !== ((i == 2) || (i == 8))) begin errors++; $display("FAIL rr_c_ack[%0d]: got %b expected %b", i, bus_d.c_ack, (i == 2) || (i == 8)); end
      checks++; if (bus_d.l_ack !== (i == 5)) begin errors++; $display("FAIL rr_l_ack[%0d]: got %b expected %b", i, bus_d.l_ack, i == 5); end
      if (i == 4) begin
        checks++; if (bus_d.m_addr !== 32'h20) begin errors++; $display("FAIL rr_loader_addr: got %h expected 20", bus_d.m_addr); end
      end
    end
    bus_d.c_req = 0; bus_d.l_req = 0;
    tick();
    checks++; if (bus_d.l_rdata !== 32'h1111_2222) begin errors++; $display("FAIL rr_l_rdata: got %h expected 11112222", bus_d.l_rdata); end
    tick();
  endtask

  task automatic test_core_read();
    bus_d.c_req = 1; bus_d.c_we = 0; bus_d.c_addr = 32'h100;
    bus_d.m_ready = 1; bus_d.m_rdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (bus_d.m_valid !== 1'b1 || bus_d.m_addr !== 32'h100 || bus_d.m_we !== 1'b0) begin errors++; $display("FAIL cr_access: got valid=%b addr=%h we=%b expected 1/100/0", bus_d.m_valid, bus_d.m_addr, bus_d.m_we); end
    checks++; if (bus_d.c_ack !== 1'b0 || busy_d !== 1'b1) begin errors++; $display("FAIL cr_early: got ack=%b busy=%b expected 0/1", bus_d.c_ack, busy_d); end
    tick();
    checks++; if (bus_d.c_ack !== 1'b1 || bus_d.c_err !== 1'b0) begin errors++; $display("FAIL cr_ack: got ack=%b err=%b expected 1/0", bus_d.c_ack, bus_d.c_err); end
    checks++; if (bus_d.c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cr_rdata: got %h expected deadbeef", bus_d.c_rdata); end
    checks++; if (bus_d.l_ack !== 1'b0 || bus_d.l_err !== 1'b0) begin errors++; $display("FAIL cr_l_quiet: got ack=%b err=%b expected 0/0", bus_d.l_ack, bus_d.l_err); end
    bus_d.c_req = 0;
    tick();
    checks++; if (bus_d.c_ack !== 1'b0 || busy_d !== 1'b0) begin errors++; $display("FAIL cr_done: got ack=%b busy=%b expected 0/0", bus_d.c_ack, busy_d); end
  endtask

  task automatic test_loader_write();
    bus_d.l_req = 1; bus_d.l_we = 1; bus_d.l_addr = 32'h40; bus_d.l_wdata = 32'h1234_5678;
    bus_d.m_ready = 0; bus_d.m_rdata = 32'hBAD0_BAD0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (bus_d.m_valid !== 1'b1 || bus_d.m_we !== 1'b1 || bus_d.m_addr !== 32'h40 || bus_d.m_wdata !== 32'h1234_5678) begin errors++; $display("FAIL lw_hold[%0d]: got v=%b we=%b a=%h d=%h expected 1/1/40/12345678", i, bus_d.m_valid, bus_d.m_we, bus_d.m_addr, bus_d.m_wdata); end
      checks++; if (bus_d.l_ack !== 1'b0) begin errors++; $display("FAIL lw_early_ack[%0d]: got %b expected 0", i, bus_d.l_ack); end
    end
    bus_d.m_ready = 1;
    tick();
    checks++; if (bus_d.l_ack !== 1'b1 || bus_d.l_err !== 1'b0 || bus_d.m_valid !== 1'b0) begin errors++; $display("FAIL lw_ack: got ack=%b err=%b valid=%b expected 1/0/0", bus_d.l_ack, bus_d.l_err, bus_d.m_valid); end
    checks++; if (bus_d.l_rdata !== 32'h1111_2222) begin errors++; $display("FAIL lw_rdata_kept: got %h expected 11112222", bus_d.l_rdata); end
    checks++; if (bus_d.c_ack !== 1'b0) begin errors++; $display("FAIL lw_c_quiet: got %b expected 0", bus_d.c_ack); end
    bus_d.l_req = 0; bus_d.l_we = 0; bus_d.m_ready = 0;
    tick();
  endtask

  task automatic test_timeout();
    bus_t.c_req = 1; bus_t.c_we = 0; bus_t.c_addr = 32'h200;
    bus_t.m_ready = 0; bus_t.m_rdata = 32'h7777_7777;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus_t.c_ack !== 1'b0 || bus_t.m_valid !== 1'b1) begin errors++; $display("FAIL to_wait[%0d]: got ack=%b valid=%b expected 0/1", i, bus_t.c_ack, bus_t.m_valid); end
    end
    tick();
    checks++; if (bus_t.c_ack !== 1'b1 || bus_t.c_err !== 1'b1) begin errors++; $display("FAIL to_ack_err: got ack=%b err=%b expected 1/1", bus_t.c_ack, bus_t.c_err); end
    checks++; if (bus_t.c_rdata !== 32'h0 || bus_t.l_ack !== 1'b0 || bus_t.l_err !== 1'b0) begin errors++; $display("FAIL to_side: got rdata=%h lack=%b lerr=%b expected 0/0/0", bus_t.c_rdata, bus_t.l_ack, bus_t.l_err); end
    bus_t.c_req = 0;
    tick();
    checks++; if (bus_t.c_ack !== 1'b0 || bus_t.c_err !== 1'b0 || busy_t !== 1'b0) begin errors++; $display("FAIL to_idle: got ack=%b err=%b busy=%b expected 0/0/0", bus_t.c_ack, bus_t.c_err, busy_t); end
  endtask

  task automatic test_timeout_ready();
    bus_t.c_req = 1; bus_t.c_we = 0; bus_t.c_addr = 32'h204;
    bus_t.m_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus_t.c_ack !== 1'b0) begin errors++; $display("FAIL tr_wait[%0d]: got ack=%b expected 0", i, bus_t.c_ack); end
    end
    bus_t.m_ready = 1; bus_t.m_rdata = 32'hCAFE_F00D;
    tick();
    checks++; if (bus_t.c_ack !== 1'b1 || bus_t.c_err !== 1'b0) begin errors++; $display("FAIL tr_ack: got ack=%b err=%b expected 1/0", bus_t.c_ack, bus_t.c_err); end
    checks++; if (bus_t.c_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL tr_rdata: got %h expected cafef00d", bus_t.c_rdata); end
    bus_t.c_req = 0; bus_t.m_ready = 0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    bus_d.c_req = 1; bus_d.c_we = 0; bus_d.c_addr = 32'h300;
    bus_d.m_ready = 0;
    tick();
    checks++; if (bus_d.m_valid !== 1'b1) begin errors++; $display("FAIL rm_access: got valid=%b expected 1", bus_d.m_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus_d.m_valid !== 1'b0 || busy_d !== 1'b0) begin errors++; $display("FAIL rm_async: got valid=%b busy=%b expected 0/0", bus_d.m_valid, busy_d); end
    bus_d.m_ready = 1; bus_d.m_rdata = 32'h55AA_55AA;
    tick();
    checks++; if (bus_d.c_ack !== 1'b0 || bus_d.m_valid !== 1'b0) begin errors++; $display("FAIL rm_held: got ack=%b valid=%b expected 0/0", bus_d.c_ack, bus_d.m_valid); end
    reset_n = 1'b1;
    tick();
    checks++; if (bus_d.m_valid !== 1'b1 || bus_d.m_addr !== 32'h300 || bus_d.c_ack !== 1'b0) begin errors++; $display("FAIL rm_regrant: got valid=%b addr=%h ack=%b expected 1/300/0", bus_d.m_valid, bus_d.m_addr, bus_d.c_ack); end
    tick();
    checks++; if (bus_d.c_ack !== 1'b1 || bus_d.c_rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL rm_ack: got ack=%b rdata=%h expected 1/55aa55aa", bus_d.c_ack, bus_d.c_rdata); end
    bus_d.c_req = 0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_core_read();
    test_loader_write();
    test_timeout();
    test_timeout_ready();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
